// File: rtl/tamarac_pkg.sv
// Shared definitions for the Tamarac sequencer: ALU modes, opcodes, FSM states,
// ALU in2 source codes and the bundled control-output word.
package tamarac_pkg;

  localparam int OPC_W = 3;

  // ALU mode codes, also decoded by the ALU itself
  localparam logic [1:0] ALU_NUL = 2'd0;
  localparam logic [1:0] ALU_INC = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd2;
  localparam logic [1:0] ALU_ADD = 2'd3;

  localparam logic [1:0] IN2_PC  = 2'd0;
  localparam logic [1:0] IN2_MDR = 2'd1;
  localparam logic [1:0] IN2_IMM = 2'd2;

  typedef enum logic [OPC_W-1:0] {
    OP_JZERO = 3'd0,
    OP_JMP   = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_LD    = 3'd4,
    OP_ST    = 3'd5,
    OP_NOP   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_F_ADDR  = 4'd1,
    S_F_WAIT  = 4'd2,
    S_PC_INC  = 4'd3,
    S_DECODE  = 4'd4,
    S_E_ADDR  = 4'd5,
    S_RD_WAIT = 4'd6,
    S_ALU_WB  = 4'd7,
    S_WR_WAIT = 4'd8,
    S_JUMP    = 4'd9,
    S_HALT    = 4'd10
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] alu_mode;
    logic [1:0] in2_sel;
    logic       pc_sel;
    logic       mar_sel;
    logic       pc_ld;
    logic       acc_ld;
    logic       ir_ld;
    logic       mar_ld;
    logic       mdr_ld;
    logic       halted;
  } ctrl_t;

  // Opcodes that need an operand address phase (E_ADDR) after decode
  function automatic logic is_mem_op(opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/tamarac_ctrl_decode.sv
// Combinational state/opcode -> control decoder. Moore outputs except the
// IR/MDR load strobes, which fire only on the memory ack cycle.
module tamarac_ctrl_decode
  import tamarac_pkg::*;
(
  input  state_e  state,
  input  opcode_e op,
  input  logic    mem_ack,
  output ctrl_t   ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.alu_mode = ALU_NUL;
    ctrl.in2_sel  = IN2_PC;
    case (state)
      S_F_ADDR: begin
        ctrl.mar_sel = 1'b0;
        ctrl.mar_ld  = 1'b1;
      end
      S_F_WAIT: begin
        ctrl.mem_req = 1'b1;
        ctrl.ir_ld   = mem_ack;
      end
      S_PC_INC: begin
        ctrl.in2_sel  = IN2_PC;
        ctrl.alu_mode = ALU_INC;
        ctrl.pc_sel   = 1'b0;
        ctrl.pc_ld    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_sel = 1'b1;
        ctrl.pc_ld  = 1'b1;
      end
      S_E_ADDR: begin
        ctrl.mar_sel = 1'b1;
        ctrl.mar_ld  = 1'b1;
      end
      S_RD_WAIT: begin
        ctrl.mem_req = 1'b1;
        ctrl.mdr_ld  = mem_ack;
      end
      S_ALU_WB: begin
        ctrl.in2_sel = IN2_MDR;
        ctrl.acc_ld  = 1'b1;
        // LD keeps NUL: the datapath ACC mux takes MDR straight through
        case (op)
          OP_ADD:  ctrl.alu_mode = ALU_ADD;
          OP_SUB:  ctrl.alu_mode = ALU_SUB;
          default: ctrl.alu_mode = ALU_NUL;
        endcase
      end
      S_WR_WAIT: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/tamarac_ctrl.sv
// Tamarac fetch/decode/execute sequencer: state register, next-state logic and
// the opcode latched at DECODE; outputs come from tamarac_ctrl_decode.
module tamarac_ctrl
  import tamarac_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [OP_W-1:0] ir_op,
  input  logic            acc_zero,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [1:0]      alu_mode,
  output logic [1:0]      in2_sel,
  output logic            pc_sel,
  output logic            mar_sel,
  output logic            pc_ld,
  output logic            acc_ld,
  output logic            ir_ld,
  output logic            mar_ld,
  output logic            mdr_ld,
  output logic            halted
);

  state_e  state, state_nxt;
  opcode_e op_q;
  opcode_e ir_opc;
  ctrl_t   ctrl;

  assign ir_opc = opcode_e'(ir_op[OPC_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Opcode captured once at DECODE so the execute phases never depend on IR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  op_q <= OP_NOP;
    else if (state == S_DECODE)  op_q <= ir_opc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run) state_nxt = S_F_ADDR;
      S_F_ADDR:  state_nxt = S_F_WAIT;
      S_F_WAIT:  if (mem_ack) state_nxt = S_PC_INC;
      S_PC_INC:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (ir_opc)
          OP_JMP:   state_nxt = S_JUMP;
          OP_JZERO: state_nxt = acc_zero ? S_JUMP : S_F_ADDR;
          OP_HALT:  state_nxt = S_HALT;
          OP_NOP:   state_nxt = S_F_ADDR;
          default:  state_nxt = is_mem_op(ir_opc) ? S_E_ADDR : S_F_ADDR;
        endcase
      end
      S_JUMP:    state_nxt = S_F_ADDR;
      S_E_ADDR:  state_nxt = (op_q == OP_ST) ? S_WR_WAIT : S_RD_WAIT;
      S_RD_WAIT: if (mem_ack) state_nxt = S_ALU_WB;
      S_ALU_WB:  state_nxt = S_F_ADDR;
      S_WR_WAIT: if (mem_ack) state_nxt = S_F_ADDR;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  tamarac_ctrl_decode u_decode (
    .state   (state),
    .op      (op_q),
    .mem_ack (mem_ack),
    .ctrl    (ctrl)
  );

  assign mem_req  = ctrl.mem_req;
  assign mem_we   = ctrl.mem_we;
  assign alu_mode = ctrl.alu_mode;
  assign in2_sel  = ctrl.in2_sel;
  assign pc_sel   = ctrl.pc_sel;
  assign mar_sel  = ctrl.mar_sel;
  assign pc_ld    = ctrl.pc_ld;
  assign acc_ld   = ctrl.acc_ld;
  assign ir_ld    = ctrl.ir_ld;
  assign mar_ld   = ctrl.mar_ld;
  assign mdr_ld   = ctrl.mdr_ld;
  assign halted   = ctrl.halted;

endmodule

// File: tb/tb_tamarac_ctrl.sv
// Scoreboard bench for tamarac_ctrl: each instruction is expanded into its
// expected per-cycle control word; a negedge monitor pops and compares.
module tb_tamarac_ctrl;

  typedef struct packed {
    logic       req;
    logic       we;
    logic [1:0] mode;
    logic [1:0] in2;
    logic       pcs;
    logic       mars;
    logic       pcld;
    logic       accld;
    logic       irld;
    logic       marld;
    logic       mdrld;
    logic       hlt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [2:0] ir_op;
  logic       acc_zero;
  logic       mem_ack;
  logic       mem_req, mem_we, pc_sel, mar_sel;
  logic [1:0] alu_mode, in2_sel;
  logic       pc_ld, acc_ld, ir_ld, mar_ld, mdr_ld, halted;

  int checks = 0;
  int errors = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  tamarac_ctrl #(.OP_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .ir_op    (ir_op),
    .acc_zero (acc_zero),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .alu_mode (alu_mode),
    .in2_sel  (in2_sel),
    .pc_sel   (pc_sel),
    .mar_sel  (mar_sel),
    .pc_ld    (pc_ld),
    .acc_ld   (acc_ld),
    .ir_ld    (ir_ld),
    .mar_ld   (mar_ld),
    .mdr_ld   (mdr_ld),
    .halted   (halted)
  );

  // Expected control words, written directly from the instruction timing rules
  function automatic obs_t mk(logic req, logic we, logic [1:0] mode, logic [1:0] in2,
                              logic pcs, logic mars, logic pcld, logic accld,
                              logic irld, logic marld, logic mdrld, logic hlt);
    obs_t e;
    e = {req, we, mode, in2, pcs, mars, pcld, accld, irld, marld, mdrld, hlt};
    return e;
  endfunction

  localparam obs_t E_ZERO  = '0;
  obs_t E_FADDR, E_FWAIT, E_FACK, E_PCINC, E_JUMP, E_EADDR, E_RWAIT, E_RACK, E_WWAIT, E_HALT;

  function automatic obs_t e_wb(logic [2:0] op);
    logic [1:0] m;
    m = (op == 3'd2) ? 2'd3 : (op == 3'd3) ? 2'd2 : 2'd0;
    return mk(0, 0, m, 2'd1, 0, 0, 0, 1, 0, 0, 0, 0);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input obs_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic cyc(input obs_t e, input logic ack, input logic az, input logic rn,
                     input string tag);
    @(posedge clk); #1;
    mem_ack  = ack;
    acc_zero = az;
    run      = rn;
    push(e, tag);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ack = 1'b1; run = rb(); acc_zero = rb();
    push(E_ZERO, "rst_assert");
    repeat (n - 1) cyc(E_ZERO, rb(), rb(), rb(), "rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ack = 1'b1; run = 1'b0;
    push(E_ZERO, "rst_release");
    cyc(E_ZERO, 1'b1, rb(), 1'b0, "idle_late_ack");
  endtask

  task automatic start();
    cyc(E_ZERO, rb(), rb(), 1'b1, "idle_run");
  endtask

  // One instruction from F_ADDR up to (not including) the next F_ADDR
  task automatic exec(input logic [2:0] op, input logic az, input int fw, input int xw);
    cyc(E_FADDR, rb(), rb(), rb(), "f_addr");
    repeat (fw) cyc(E_FWAIT, 1'b0, rb(), rb(), "f_wait");
    cyc(E_FACK, 1'b1, rb(), rb(), "f_ack");
    ir_op = op;
    cyc(E_PCINC, rb(), rb(), rb(), "pc_inc");
    cyc(E_ZERO, rb(), az, rb(), "decode");
    case (op)
      3'd0: if (az) cyc(E_JUMP, rb(), rb(), rb(), "jzero_jump");
      3'd1: cyc(E_JUMP, rb(), rb(), rb(), "jmp_jump");
      3'd2, 3'd3, 3'd4: begin
        cyc(E_EADDR, rb(), rb(), rb(), "rd_e_addr");
        repeat (xw) cyc(E_RWAIT, 1'b0, rb(), rb(), "rd_wait");
        cyc(E_RACK, 1'b1, rb(), rb(), "rd_ack");
        cyc(e_wb(op), rb(), rb(), rb(), "alu_wb");
      end
      3'd5: begin
        cyc(E_EADDR, rb(), rb(), rb(), "st_e_addr");
        repeat (xw) cyc(E_WWAIT, 1'b0, rb(), rb(), "wr_wait");
        cyc(E_WWAIT, 1'b1, rb(), rb(), "wr_ack");
      end
      3'd7: repeat (8) cyc(E_HALT, rb(), rb(), rb(), "halt");
      default: ;
    endcase
  endtask

  always @(negedge clk) begin : monitor
    obs_t  e, o;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = {mem_req, mem_we, alu_mode, in2_sel, pc_sel, mar_sel,
           pc_ld, acc_ld, ir_ld, mar_ld, mdr_ld, halted};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s @%0t: got %b required %b", t, $time, o, e);
      end
    end
  end

  initial begin
    E_FADDR = mk(0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0);
    E_FWAIT = mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_FACK  = mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
    E_PCINC = mk(0, 0, 2'd1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0);
    E_JUMP  = mk(0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0);
    E_EADDR = mk(0, 0, 2'd0, 2'd0, 0, 1, 0, 0, 0, 1, 0, 0);
    E_RWAIT = mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_RACK  = mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0);
    E_WWAIT = mk(1, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_HALT  = mk(0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1);

    rst_n = 1'b0; run = 1'b0; ir_op = 3'd0; acc_zero = 1'b0; mem_ack = 1'b0;
    repeat (2) cyc(E_ZERO, rb(), rb(), rb(), "in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
    push(E_ZERO, "idle_after_rst");
    repeat (3) cyc(E_ZERO, rb(), rb(), 1'b0, "idle_no_run");

    // Directed cases
    start();
    exec(3'd6, rb(), 0, 0);   // NOP, 4 cycles
    exec(3'd2, rb(), 0, 3);   // ADD, 3 extra read waits
    exec(3'd5, rb(), 0, 0);   // ST, 6 cycles
    exec(3'd0, 1'b1, 0, 0);   // JZERO taken
    exec(3'd0, 1'b0, 0, 0);   // JZERO not taken
    exec(3'd3, rb(), 2, 1);   // SUB with fetch and read waits
    exec(3'd4, rb(), 0, 0);   // LD
    exec(3'd1, rb(), 1, 0);   // JMP
    exec(3'd5, rb(), 0, 2);   // ST with write waits

    // Randomised program (no HALT)
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 6));
      exec(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset mid-RD_WAIT: mem_req must drop within the same cycle
    cyc(E_FADDR, rb(), rb(), rb(), "f_addr");
    cyc(E_FACK, 1'b1, rb(), rb(), "f_ack");
    ir_op = 3'd4;
    cyc(E_PCINC, rb(), rb(), rb(), "pc_inc");
    cyc(E_ZERO, rb(), rb(), rb(), "decode");
    cyc(E_EADDR, rb(), rb(), rb(), "rd_e_addr");
    cyc(E_RWAIT, 1'b0, rb(), rb(), "rd_wait_pre_rst");
    do_reset(2);

    // HALT sticks through run toggles and stray acks, cleared only by reset
    start();
    exec(3'd6, rb(), 0, 0);
    exec(3'd7, rb(), 0, 0);
    do_reset(1);
    repeat (2) cyc(E_ZERO, rb(), rb(), 1'b0, "idle_post_halt");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tamarac_ctrl.md
# tamarac_ctrl

Fetch/decode/execute sequencer for the Tamarac 16-bit datapath, sitting directly upstream of the ALU. It drives the ALU `mode` code, the ALU operand selects, the register load strobes (PC, ACC, IR, MAR, MDR) and a request/acknowledge memory handshake. It takes the opcode from IR and the ACC-zero flag from the datapath.

## Interface

- `OP_W`, default 3: opcode width, IR[15:13].
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: starts execution from `IDLE`.
- `ir_op`, input, `OP_W`: opcode field of the current IR.
- `acc_zero`, input, 1: ACC == 0, from the datapath.
- `mem_ack`, input, 1: memory completes the current request.
- `mem_req`, output, 1: memory request.
- `mem_we`, output, 1: write qualifier, valid while `mem_req` is high.
- `alu_mode`, output, 2: NUL=0, INC=1, SUB=2, ADD=3.
- `in2_sel`, output, 2: ALU in2 source: 0 PC, 1 MDR, 2 IR[12:0] zero-extended. ALU in1 is always ACC.
- `pc_sel`, output, 1: PC load source: 0 ALU out, 1 IR[12:0].
- `mar_sel`, output, 1: MAR load source: 0 PC, 1 IR[12:0].
- `pc_ld`, `acc_ld`, `ir_ld`, `mar_ld`, `mdr_ld`, outputs, 1 each: register load strobes.
- `halted`, output, 1: high in state `HALT`.

## Operation

- Opcodes: 0 JZERO, 1 JMP, 2 ADD, 3 SUB, 4 LD, 5 ST, 6 NOP, 7 HALT.
- States: `IDLE`, `F_ADDR`, `F_WAIT`, `PC_INC`, `DECODE`, `E_ADDR`, `RD_WAIT`, `ALU_WB`, `WR_WAIT`, `JUMP`, `HALT`.
- `IDLE` -> `F_ADDR` when `run`=1, otherwise stay.
- `F_ADDR`: `mar_sel`=0, `mar_ld`=1.
- `F_WAIT`:
  - `mem_req`=1, `mem_we`=0.
  - `ir_ld`=`mem_ack`.
  - Stay until `mem_ack`, then -> `PC_INC`.
- `PC_INC`: `in2_sel`=0, `alu_mode`=INC, `pc_sel`=0, `pc_ld`=1.
- `DECODE`: samples `ir_op` and `acc_zero`, then branches:
  - JMP -> `JUMP`.
  - JZERO -> `JUMP` if `acc_zero`, else `F_ADDR`.
  - ADD, SUB, LD, ST -> `E_ADDR`.
  - NOP -> `F_ADDR`.
  - HALT -> `HALT`.
- `JUMP`: `pc_sel`=1, `pc_ld`=1, then -> `F_ADDR`.
- `E_ADDR`: `mar_sel`=1, `mar_ld`=1, then -> `WR_WAIT` for ST, else -> `RD_WAIT`.
- `RD_WAIT`:
  - `mem_req`=1, `mem_we`=0.
  - `mdr_ld`=`mem_ack`.
  - On ack -> `ALU_WB`.
- `ALU_WB`: `in2_sel`=1, `acc_ld`=1, then -> `F_ADDR`. `alu_mode` by opcode:
  - ADD: ADD.
  - SUB: SUB.
  - LD: NUL+MDR path, i.e. `alu_mode`=ADD with the datapath forcing in1=0 via `alu_mode`... no. LD uses `alu_mode`=INC with `in2_sel`=1 is wrong. **Decided:** LD loads ACC from MDR directly by asserting `acc_ld` with `alu_mode`=NUL; the datapath ACC mux selects MDR when `alu_mode`=NUL.
- `WR_WAIT`: `mem_req`=1, `mem_we`=1; the datapath drives ACC onto the write data. On ack -> `F_ADDR`.
- `HALT`: `halted`=1. Exit only by reset; `run` is ignored.
- Output decode:
  - All outputs are Moore decodes of the state, except `ir_ld`/`mdr_ld`, which are qualified by `mem_ack`.
  - Every output not listed for a state is 0, and `alu_mode`=NUL.

## Timing

- Reset, asynchronous: state=`IDLE`; every output 0, `alu_mode`=NUL.
- Reset mid-transaction drops `mem_req` immediately. A late `mem_ack` is then ignored.
- `mem_ack` is accepted only in `F_WAIT`, `RD_WAIT` or `WR_WAIT`; an ack in any other state has no effect.
- Handshake:
  - `mem_req` and `mem_we` are stable from wait-state entry until the ack cycle.
  - `mem_req` is low in the cycle after the ack.
  - Same-cycle ack gives a 1-cycle wait state.
- Cycles per instruction with zero-wait memory (ack in the first wait cycle), from `F_ADDR` to the next `F_ADDR`:
  - NOP: 4.
  - JZERO not taken: 4.
  - JZERO taken: 5.
  - JMP: 5.
  - ST: 6.
  - ADD, SUB, LD: 7.
  - Each extra wait cycle adds 1.
- `acc_zero` is sampled only in `DECODE`. An ACC write in `ALU_WB` is visible to the next instruction's `DECODE`.
- `run` deasserting after leaving `IDLE` has no effect.

## Structure

- Package `tamarac_pkg`: ALU mode constants (shared with the ALU), opcode constants, state enum, `in2_sel` codes.
- Sub-module `tamarac_ctrl_decode`: combinational state+opcode -> control-output decoder. The top level holds the state register and next-state logic.

## Test plan

- Reset with `run`=0 -> stays `IDLE`, all outputs 0. Pulse `rst_n` low while in `RD_WAIT` -> `mem_req` low immediately, state `IDLE`.
- NOP, zero-wait ack -> `mar_ld`, `mem_req`+`ir_ld`, `pc_ld` with `alu_mode`=1, `DECODE`; back in `F_ADDR` 4 cycles after start.
- ADD with `mem_ack` delayed 3 cycles -> `mem_req` held 3 cycles, `mdr_ld` only on the ack cycle, then `acc_ld` with `alu_mode`=3 and `in2_sel`=1; 9 cycles total.
- ST -> `mar_sel`=1 in `E_ADDR`, `mem_we`=1 for the whole of `WR_WAIT`, `acc_ld` never asserted; 6 cycles.
- JZERO with `acc_zero`=1 -> `pc_sel`=1, `pc_ld` in `JUMP` (5 cycles). With `acc_zero`=0 -> no `JUMP`, 4 cycles.
- HALT -> `halted`=1 and stays there while `run` toggles and spurious `mem_ack` pulses arrive; `rst_n` low -> `IDLE`, `halted`=0.
